// File: rtl/vga_timing_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl_pkg
// Shared constants for the VGA timing controller:
//   - default 640x480@60 segment lengths (clocks / lines)
//   - RGB332 colour constants and the 8-entry colour-bar table
//   - axis_w(): counter width for an axis of a given total length
// No ports (package).
// -----------------------------------------------------------------------------
package vga_timing_ctrl_pkg;

   // Default 640x480@60 horizontal segments (pixel clocks)
   localparam int H_SYNC_DEF   = 96;
   localparam int H_BACK_DEF   = 40;
   localparam int H_LEFT_DEF   = 8;
   localparam int H_VALID_DEF  = 640;
   localparam int H_RIGHT_DEF  = 8;
   localparam int H_FRONT_DEF  = 8;

   // Default 640x480@60 vertical segments (lines)
   localparam int V_SYNC_DEF   = 2;
   localparam int V_BACK_DEF   = 25;
   localparam int V_TOP_DEF    = 8;
   localparam int V_VALID_DEF  = 480;
   localparam int V_BOTTOM_DEF = 8;
   localparam int V_FRONT_DEF  = 2;

   localparam int DATA_W_DEF   = 8;
   localparam int COORD_W_DEF  = 10;

   typedef logic [7:0] rgb332_t;

   // RGB332 colours: RRR_GGG_BB
   localparam rgb332_t RGB_WHITE   = 8'hFF;
   localparam rgb332_t RGB_YELLOW  = 8'hFC;
   localparam rgb332_t RGB_CYAN    = 8'h1F;
   localparam rgb332_t RGB_GREEN   = 8'h1C;
   localparam rgb332_t RGB_MAGENTA = 8'hE3;
   localparam rgb332_t RGB_RED     = 8'hE0;
   localparam rgb332_t RGB_BLUE    = 8'h03;
   localparam rgb332_t RGB_BLACK   = 8'h00;

   localparam int N_BARS = 8;

   // Classic colour-bar order, left to right
   function automatic rgb332_t bar_colour(input logic [2:0] idx);
      case (idx)
         3'd0:    return RGB_WHITE;
         3'd1:    return RGB_YELLOW;
         3'd2:    return RGB_CYAN;
         3'd3:    return RGB_GREEN;
         3'd4:    return RGB_MAGENTA;
         3'd5:    return RGB_RED;
         3'd6:    return RGB_BLUE;
         default: return RGB_BLACK;
      endcase
   endfunction

   // $clog2 of 1 is 0, which would give a zero-width counter
   function automatic int axis_w(input int total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl_if
// Pixel-request bus between the timing controller and its pixel source.
//   pix_req  : controller asks for the pixel at (pix_x, pix_y)
//   pix_x/y  : requested coordinate, all-ones while pix_req=0
//   pix_data : source answer, valid one clock after pix_req
// Modports: master = timing controller, slave = pixel source.
// -----------------------------------------------------------------------------
interface vga_timing_ctrl_if
   import vga_timing_ctrl_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int COORD_W = COORD_W_DEF
);
   logic               pix_req;
   logic [COORD_W-1:0] pix_x;
   logic [COORD_W-1:0] pix_y;
   logic [DATA_W-1:0]  pix_data;

   modport master (output pix_req, output pix_x, output pix_y, input  pix_data);
   modport slave  (input  pix_req, input  pix_x, input  pix_y, output pix_data);
endinterface

// File: rtl/vga_axis_cnt.sv
// -----------------------------------------------------------------------------
// vga_axis_cnt
// One timing axis (horizontal or vertical): counter 0..TOTAL-1 with wrap,
// plus window decode of the registered count.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clr        : force count to 0 on next clock (has priority over adv)
//   adv        : advance by one (wraps after TOTAL-1)
//   cnt        : current count
//   in_sync    : cnt < SYNC
//   in_act     : cnt in [ACT_LO, ACT_LO+ACT_LEN-1]
//   in_req     : same window shifted LEAD positions earlier
//   req_pos    : cnt relative to start of the request window
// -----------------------------------------------------------------------------
module vga_axis_cnt
   import vga_timing_ctrl_pkg::*;
#(
   parameter int TOTAL   = 800,
   parameter int SYNC    = 96,
   parameter int ACT_LO  = 144,
   parameter int ACT_LEN = 640,
   parameter int LEAD    = 1,
   parameter int W       = axis_w(TOTAL)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         adv,
   output logic [W-1:0] cnt,
   output logic         in_sync,
   output logic         in_act,
   output logic         in_req,
   output logic [W-1:0] req_pos
);
   localparam int REQ_LO = ACT_LO - LEAD;

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         last;

   assign last = (int'(cnt_q) == TOTAL - 1);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (adv) begin
         cnt_d = last ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt     = cnt_q;
   assign in_sync = (int'(cnt_q) < SYNC);
   assign in_act  = (int'(cnt_q) >= ACT_LO) && (int'(cnt_q) <= ACT_LO + ACT_LEN - 1);
   assign in_req  = (int'(cnt_q) >= REQ_LO) && (int'(cnt_q) <= REQ_LO + ACT_LEN - 1);
   assign req_pos = cnt_q - W'(REQ_LO);
endmodule

// File: rtl/vga_timing_ctrl.sv
// -----------------------------------------------------------------------------
// vga_timing_ctrl
// Parametrised VGA timing generator: hsync/vsync, pixel request with
// coordinates, blanked RGB, frame/line strobes.
// Ports:
//   vga_clk, sys_rst_n : pixel clock, async active-low reset
//   timing_en          : 1 = run, 0 = counters held at 0 and outputs idle
//   test_mode          : (VGA_TEST_PATTERN_EN only) 1 = colour bars on rgb
//   pix_if (master)    : pix_req/pix_x/pix_y out, pix_data in (1-cycle latency)
//   rgb, rgb_valid     : pixel to DAC (0 when blanked), active-area flag
//   hsync, vsync       : sync pulses, polarity from SYNC_POL
//   frame_start        : 1-cycle pulse at h=0,v=0
//   line_start         : 1-cycle pulse at every h=0
// Build option: define VGA_TEST_PATTERN_EN to add the test_mode port and the
// built-in colour-bar generator.
// -----------------------------------------------------------------------------
module vga_timing_ctrl
   import vga_timing_ctrl_pkg::*;
#(
   parameter int H_SYNC   = H_SYNC_DEF,
   parameter int H_BACK   = H_BACK_DEF,
   parameter int H_LEFT   = H_LEFT_DEF,
   parameter int H_VALID  = H_VALID_DEF,
   parameter int H_RIGHT  = H_RIGHT_DEF,
   parameter int H_FRONT  = H_FRONT_DEF,
   parameter int V_SYNC   = V_SYNC_DEF,
   parameter int V_BACK   = V_BACK_DEF,
   parameter int V_TOP    = V_TOP_DEF,
   parameter int V_VALID  = V_VALID_DEF,
   parameter int V_BOTTOM = V_BOTTOM_DEF,
   parameter int V_FRONT  = V_FRONT_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int COORD_W  = COORD_W_DEF,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic               vga_clk,
   input  logic               sys_rst_n,
   input  logic               timing_en,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               test_mode,
`endif
   vga_timing_ctrl_if.master  pix_if,
   output logic [DATA_W-1:0]  rgb,
   output logic               rgb_valid,
   output logic               hsync,
   output logic               vsync,
   output logic               frame_start,
   output logic               line_start
);
   localparam int H_TOTAL = H_SYNC + H_BACK + H_LEFT + H_VALID + H_RIGHT + H_FRONT;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_TOP + V_VALID + V_BOTTOM + V_FRONT;
   localparam int HA      = H_SYNC + H_BACK + H_LEFT;
   localparam int VA      = V_SYNC + V_BACK + V_TOP;
   localparam int HW      = axis_w(H_TOTAL);
   localparam int VW      = axis_w(V_TOTAL);

   // run_q marks cycles in which the counters represent a live raster
   // position. It lags timing_en by one clock, so the first enabled cycle
   // shows h=0,v=0 (and hence frame_start) and reset/disable give idle outputs.
   logic run_q;
   logic run_d;

   always_comb begin
      run_d = timing_en;
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         run_q <= 1'b0;
      end else begin
         run_q <= run_d;
      end
   end

   logic [HW-1:0] h_cnt, h_req_pos;
   logic [VW-1:0] v_cnt, v_req_pos;
   logic          h_sync, h_act, h_req, h_last;
   logic          v_sync, v_act, v_req;

   assign h_last = (h_cnt == HW'(H_TOTAL - 1));

   vga_axis_cnt #(
      .TOTAL(H_TOTAL), .SYNC(H_SYNC), .ACT_LO(HA), .ACT_LEN(H_VALID), .LEAD(1), .W(HW)
   ) u_h_axis (
      .clk(vga_clk), .rst_n(sys_rst_n), .clr(~timing_en), .adv(run_q),
      .cnt(h_cnt), .in_sync(h_sync), .in_act(h_act), .in_req(h_req), .req_pos(h_req_pos)
   );

   // Vertical window has no lead: the request row equals the display row.
   vga_axis_cnt #(
      .TOTAL(V_TOTAL), .SYNC(V_SYNC), .ACT_LO(VA), .ACT_LEN(V_VALID), .LEAD(0), .W(VW)
   ) u_v_axis (
      .clk(vga_clk), .rst_n(sys_rst_n), .clr(~timing_en), .adv(run_q & h_last),
      .cnt(v_cnt), .in_sync(v_sync), .in_act(v_act), .in_req(v_req), .req_pos(v_req_pos)
   );

   logic              pix_req;
   logic [DATA_W-1:0] pix_sel;

   assign pix_req        = run_q & h_req & v_req;
   assign pix_if.pix_req = pix_req;
   assign pix_if.pix_x   = pix_req ? COORD_W'(h_req_pos) : '1;
   assign pix_if.pix_y   = pix_req ? COORD_W'(v_req_pos) : '1;

   assign rgb_valid   = run_q & h_act & v_act;
   assign hsync       = (run_q & h_sync) ? SYNC_POL : ~SYNC_POL;
   assign vsync       = (run_q & v_sync) ? SYNC_POL : ~SYNC_POL;
   assign line_start  = run_q & (h_cnt == '0);
   assign frame_start = run_q & (h_cnt == '0) & (v_cnt == '0);

`ifdef VGA_TEST_PATTERN_EN
   // Bar index uses the displayed column (h - HA), i.e. the pix_x that was
   // requested one clock earlier.
   logic [HW-1:0] act_x;
   logic [2:0]    bar_idx;

   assign act_x   = h_cnt - HW'(HA);
   assign bar_idx = 3'((int'(act_x) * N_BARS) / H_VALID);
   assign pix_sel = test_mode ? DATA_W'(bar_colour(bar_idx)) : pix_if.pix_data;
`else
   assign pix_sel = pix_if.pix_data;
`endif

   assign rgb = rgb_valid ? pix_sel : '0;
endmodule

// File: tb/tb_vga_timing_ctrl.sv
module tb_vga_timing_ctrl;
   // Small raster: H 2,1,1,4,1,1 (total 10, active 4..7, request 3..6)
   //               V 1,1,0,3,0,1 (total 6, active lines 2..4)
   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       req;
      logic [9:0] x;
      logic [9:0] y;
      logic       valid;
      logic [7:0] rgb;
      logic       fs;
      logic       ls;
   } outs_t;

   typedef struct {
      int    c;      // raster index v*10+h
      outs_t exp;
   } spot_t;

   localparam outs_t IDLE = {1'b1, 1'b1, 1'b0, 10'h3FF, 10'h3FF, 1'b0, 8'h00, 1'b0, 1'b0};

   logic       vga_clk;
   logic       sys_rst_n;
   logic       timing_en;
   logic [7:0] rgb;
   logic       rgb_valid, hsync, vsync, frame_start, line_start;
`ifdef VGA_TEST_PATTERN_EN
   logic       test_mode;
`endif

   vga_timing_ctrl_if #(.DATA_W(8), .COORD_W(10)) pif ();

   vga_timing_ctrl #(
      .H_SYNC(2), .H_BACK(1), .H_LEFT(1), .H_VALID(4), .H_RIGHT(1), .H_FRONT(1),
      .V_SYNC(1), .V_BACK(1), .V_TOP(0), .V_VALID(3), .V_BOTTOM(0), .V_FRONT(1),
      .DATA_W(8), .COORD_W(10), .SYNC_POL(1'b0)
   ) dut (
      .vga_clk     (vga_clk),
      .sys_rst_n   (sys_rst_n),
      .timing_en   (timing_en),
`ifdef VGA_TEST_PATTERN_EN
      .test_mode   (test_mode),
`endif
      .pix_if      (pif),
      .rgb         (rgb),
      .rgb_valid   (rgb_valid),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start),
      .line_start  (line_start)
   );

   initial vga_clk = 1'b0;
   always #5 vga_clk = ~vga_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   int    n_tests = 0;
   int    n_fail  = 0;
   int    m_h = 0, m_v = 0;
   bit    m_act = 0;
   bit    tm = 0;
   outs_t exp_q[$];
   spot_t spot[13];

   function automatic outs_t mk(input bit hs, input bit vs, input bit req,
                                input logic [9:0] x, input logic [9:0] y,
                                input bit valid, input logic [7:0] c, input bit fs, input bit ls);
      outs_t o;
      o = {hs, vs, req, x, y, valid, c, fs, ls};
      return o;
   endfunction

   function automatic outs_t dut_outs();
      return outs_t'({hsync, vsync, pif.pix_req, pif.pix_x, pif.pix_y,
                      rgb_valid, rgb, frame_start, line_start});
   endfunction

   function automatic logic [7:0] bar_exp(input int x);
      // 4-pixel line, 8 bars: pixel x lands in bar 2x
      if (x == 0) return 8'hFF;
      if (x == 1) return 8'h1F;
      if (x == 2) return 8'hE3;
      return 8'h03;
   endfunction

   // Expected outputs for a raster position, straight from the timing description
   function automatic outs_t model_out(input int h, input int v, input bit act,
                                       input logic [7:0] pd, input bit tmode);
      outs_t o;
      bit    vact;
      o = IDLE;
      if (act) begin
         vact    = (v >= 2) && (v <= 4);
         o.hs    = (h < 2) ? 1'b0 : 1'b1;
         o.vs    = (v < 1) ? 1'b0 : 1'b1;
         o.req   = vact && (h >= 3) && (h <= 6);
         if (o.req) begin
            o.x = 10'(h - 3);
            o.y = 10'(v - 2);
         end
         o.valid = vact && (h >= 4) && (h <= 7);
         if (o.valid) o.rgb = tmode ? bar_exp(h - 4) : pd;
         o.fs    = (h == 0) && (v == 0);
         o.ls    = (h == 0);
      end
      return o;
   endfunction

   task automatic model_step(input bit en);
      if (!en) begin
         m_h = 0; m_v = 0; m_act = 0;
      end else begin
         if (m_act) begin
            if (m_h == 9) begin
               m_h = 0;
               m_v = (m_v == 5) ? 0 : m_v + 1;
            end else begin
               m_h = m_h + 1;
            end
         end
         m_act = 1;
      end
   endtask

   task automatic check_outs(input string name, input outs_t act, input outs_t exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h (hs=%b vs=%b req=%b x=%h y=%h val=%b rgb=%h fs=%b ls=%b) required %h (hs=%b vs=%b req=%b x=%h y=%h val=%b rgb=%h fs=%b ls=%b) @h=%0d v=%0d",
                  name, act, act.hs, act.vs, act.req, act.x, act.y, act.valid, act.rgb, act.fs, act.ls,
                  exp, exp.hs, exp.vs, exp.req, exp.x, exp.y, exp.valid, exp.rgb, exp.fs, exp.ls, m_h, m_v);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b required %b", name, act, exp);
      end
   endtask

   // One clock: drive source data for the current position, queue the
   // expectation, compare mid-cycle, then present timing_en for the next edge.
   task automatic run_cycle(input bit en_next);
      outs_t      e, a;
      logic [7:0] pd;
      int         idx;
      @(negedge vga_clk);
      if (m_act && m_v >= 2 && m_v <= 4 && m_h >= 4 && m_h <= 7)
         pd = 8'(m_h - 4 + 16);
      else
         pd = 8'($urandom_range(255, 1));
      pif.pix_data = pd;
      exp_q.push_back(model_out(m_h, m_v, m_act, pd, tm));
      #1;
      a = dut_outs();
      e = exp_q.pop_front();
      check_outs("cycle", a, e);
      idx = m_v * 10 + m_h;
      if (m_act && !tm) begin
         foreach (spot[i]) begin
            if (spot[i].c == idx) check_outs($sformatf("spot%0d", i), a, spot[i].exp);
         end
      end
      $display("[TB] h=%0d v=%0d act=%0d hs=%b vs=%b req=%b x=%0h y=%0h val=%b rgb=%h fs=%b ls=%b",
               m_h, m_v, m_act, a.hs, a.vs, a.req, a.x, a.y, a.valid, a.rgb, a.fs, a.ls);
      timing_en = en_next;
      @(posedge vga_clk);
      model_step(en_next);
   endtask

   initial begin
      // hand-derived checkpoints: {c, hs, vs, req, x, y, valid, rgb, fs, ls}
      spot[0]  = '{0,  mk(0, 0, 0, 10'h3FF, 10'h3FF, 0, 8'h00, 1, 1)};
      spot[1]  = '{2,  mk(1, 0, 0, 10'h3FF, 10'h3FF, 0, 8'h00, 0, 0)};
      spot[2]  = '{10, mk(0, 1, 0, 10'h3FF, 10'h3FF, 0, 8'h00, 0, 1)};
      spot[3]  = '{23, mk(1, 1, 1, 10'h000, 10'h000, 0, 8'h00, 0, 0)};
      spot[4]  = '{24, mk(1, 1, 1, 10'h001, 10'h000, 1, 8'h10, 0, 0)};
      spot[5]  = '{26, mk(1, 1, 1, 10'h003, 10'h000, 1, 8'h12, 0, 0)};
      spot[6]  = '{27, mk(1, 1, 0, 10'h3FF, 10'h3FF, 1, 8'h13, 0, 0)};
      spot[7]  = '{28, mk(1, 1, 0, 10'h3FF, 10'h3FF, 0, 8'h00, 0, 0)};
      spot[8]  = '{30, mk(0, 1, 0, 10'h3FF, 10'h3FF, 0, 8'h00, 0, 1)};
      spot[9]  = '{43, mk(1, 1, 1, 10'h000, 10'h002, 0, 8'h00, 0, 0)};
      spot[10] = '{47, mk(1, 1, 0, 10'h3FF, 10'h3FF, 1, 8'h13, 0, 0)};
      spot[11] = '{53, mk(1, 1, 0, 10'h3FF, 10'h3FF, 0, 8'h00, 0, 0)};
      spot[12] = '{57, mk(1, 1, 0, 10'h3FF, 10'h3FF, 0, 8'h00, 0, 0)};

      // Reset held with enable high: outputs must stay idle
      sys_rst_n    = 1'b0;
      timing_en    = 1'b1;
      pif.pix_data = 8'h5A;
`ifdef VGA_TEST_PATTERN_EN
      test_mode    = 1'b0;
`endif
      repeat (2) @(negedge vga_clk);
      #1 check_outs("reset_state", dut_outs(), IDLE);
      @(negedge vga_clk);
      #1 check_outs("reset_hold", dut_outs(), IDLE);
      sys_rst_n = 1'b1;
      @(posedge vga_clk);
      model_step(1'b1);

      // Two full frames
      repeat (120) run_cycle(1'b1);

      // Disable at h=6,v=3
      for (int k = 0; k < 100 && !(m_act && m_h == 6 && m_v == 3); k++) run_cycle(1'b1);
      check_bit("reach_h6v3", (m_h == 6 && m_v == 3), 1'b1);
      run_cycle(1'b0);
      #2 check_outs("disable_idle", dut_outs(), IDLE);
      repeat (3) run_cycle(1'b0);
      run_cycle(1'b1);
      #2;
      check_bit("reenable_fs", frame_start, 1'b1);
      check_bit("reenable_hs", hsync, 1'b0);
      repeat (25) run_cycle(1'b1);

      // Asynchronous reset mid-line, away from any clock edge
      @(negedge vga_clk);
      #2 sys_rst_n = 1'b0;
      #1 check_outs("async_reset", dut_outs(), IDLE);
      m_h = 0; m_v = 0; m_act = 0;
      @(negedge vga_clk);
      sys_rst_n = 1'b1;
      @(posedge vga_clk);
      model_step(timing_en);
      #2 check_bit("post_reset_fs", frame_start, 1'b1);
      repeat (60) run_cycle(1'b1);

`ifdef VGA_TEST_PATTERN_EN
      tm        = 1'b1;
      test_mode = 1'b1;
      repeat (60) run_cycle(1'b1);
      tm        = 1'b0;
      test_mode = 1'b0;
      repeat (10) run_cycle(1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
